// File: rtl/btn_run_ctrl.sv
// btn_run_ctrl: stopwatch push-button conditioning and run/stop control.
// The start/stop and clear buttons each pass through a 2-FF synchroniser,
// a counter-based debouncer and a rising-edge detector. A two-state run FSM
// drives the counter freeze level (stop) and a one-cycle clear pulse (clr).
// Optional feature: define LONG_PRESS_EN so that holding start/stop for
// LONG_CYCLES cycles also clears the counter.
// A press still held when reset is released is ignored. The button has to
// be released and pressed again before it produces a pulse.
module btn_run_ctrl #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_ss,
    input  logic btn_clr,
    output logic stop,
    output logic clr,
    output logic ss_pulse
);

    localparam int              DB_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

    // Bit 0 is start/stop and bit 1 is clear.
    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic [1:0] r_init_cnt;
    logic       w_chain_valid;
    logic       w_long_evt;
    logic       w_clr_evt;
    run_state_t r_state;
    run_state_t w_state_next;
    logic       r_clr;
    logic       r_ss_pulse;

    assign w_raw = {btn_clr, btn_ss};

    // The synchroniser outputs hold reset values for the first two edges
    // after reset. Those values must not count as "button seen released".
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_init_cnt <= 2'd0;
        end else if (r_init_cnt != 2'd2) begin
            r_init_cnt <= r_init_cnt + 2'd1;
        end
    end

    assign w_chain_valid = (r_init_cnt == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            r_sync1;
            logic            r_sync2;
            logic            r_db;
            logic            r_db_q;
            logic            r_lock;
            logic [DB_W-1:0] r_cnt;

            // 2-FF synchroniser for the raw, asynchronous button input.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // Accept a new level only after DB_CYCLES consecutive differing samples.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end

            // Keep a delayed copy of the debounced level for edge detection.
            // The lock stays set after reset until the button is seen released.
            always_ff @(posedge clk_100MHz or posedge reset) begin
                if (reset) begin
                    r_db_q <= 1'b0;
                    r_lock <= 1'b1;
                end else begin
                    r_db_q <= r_db;
                    if (w_chain_valid && !r_sync2 && !r_db) begin
                        r_lock <= 1'b0;
                    end
                end
            end

            assign w_rise[gi] = r_db & ~r_db_q & ~r_lock;
        end
    endgenerate

`ifdef LONG_PRESS_EN
    localparam int L_W = $clog2(LONG_CYCLES + 1);

    logic           w_ss_level;
    logic [L_W-1:0] r_long_cnt;

    assign w_ss_level = g_btn[0].r_db & ~g_btn[0].r_lock;

    // Count the cycles the button has been held, and stop counting at LONG_CYCLES.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_long_cnt <= '0;
        end else if (!w_ss_level) begin
            r_long_cnt <= '0;
        end else if (r_long_cnt != L_W'(LONG_CYCLES)) begin
            r_long_cnt <= r_long_cnt + L_W'(1);
        end
    end

    // Fires on the edge where the counter reaches LONG_CYCLES, once per press.
    assign w_long_evt = w_ss_level && (r_long_cnt == L_W'(LONG_CYCLES - 1));
`else
    // Long press is not built. The compare is constant 0; it only keeps
    // LONG_CYCLES referenced so both builds have the same parameter list.
    assign w_long_evt = (LONG_CYCLES < 0);
`endif

    // Next-state logic. Clear has priority over a start/stop toggle.
    always_comb begin
        w_state_next = r_state;
        w_clr_evt    = w_rise[1] | w_long_evt;
        if (w_clr_evt) begin
            w_state_next = ST_STOPPED;
        end else if (w_rise[0]) begin
            w_state_next = (r_state == ST_STOPPED) ? ST_RUNNING : ST_STOPPED;
        end
    end

    // State register and registered pulse outputs.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state    <= ST_STOPPED;
            r_clr      <= 1'b0;
            r_ss_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr      <= w_clr_evt;
            r_ss_pulse <= w_rise[0];
        end
    end

    assign stop     = (r_state == ST_STOPPED);
    assign clr      = r_clr;
    assign ss_pulse = r_ss_pulse;

endmodule

// File: tb/tb_btn_run_ctrl.sv
// Testbench for btn_run_ctrl, built with DB_CYCLES=4 and LONG_CYCLES=20.
// It uses a table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_btn_run_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_ss = 1'b0;
    logic btn_clr = 1'b0;
    logic stop;
    logic clr;
    logic ss_pulse;

    btn_run_ctrl #(
        .DB_CYCLES  (4),
        .LONG_CYCLES(20)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .btn_ss    (btn_ss),
        .btn_clr   (btn_clr),
        .stop      (stop),
        .clr       (clr),
        .ss_pulse  (ss_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ss;
        logic cl;
        logic exp_stop;
        logic exp_clr;
        logic exp_pulse;
    } vec_t;

    vec_t vecs[128];
    int   nvec = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   ed = 0;
    int   np_ss = 0;
    int   np_clr = 0;
    int   last_ss_edge = -1;
    int   last_clr_edge = -1;
    logic stop_e7;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic add(input int n, input logic s, input logic c,
                       input logic es, input logic ec, input logic ep);
        for (int k = 0; k < n; k++) begin
            vecs[nvec] = '{s, c, es, ec, ep};
            nvec++;
        end
    endtask

    // Advance one clock edge and sample 1 ns later. Pulses are counted
    // relative to the last mark().
    task automatic step();
        @(posedge clk);
        #1;
        ed++;
        if (ss_pulse === 1'b1) begin
            np_ss++;
            last_ss_edge = ed;
        end
        if (clr === 1'b1) begin
            np_clr++;
            last_clr_edge = ed;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic mark();
        ed = 0;
        np_ss = 0;
        np_clr = 0;
        last_ss_edge = -1;
        last_clr_edge = -1;
    endtask

    initial begin
        // 1: reset asserted between clock edges -> outputs take reset values at once
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_stop", int'(stop), 1);
        check("rst_async_clr", int'(clr), 0);
        check("rst_async_pulse", int'(ss_pulse), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        steps(5);

        // Table: 2 (toggle via two presses) and 4 (clear, simultaneous press)
        add(6, 1, 0, 1, 0, 0); add(1, 1, 0, 0, 0, 1); add(3, 1, 0, 0, 0, 0); add(10, 0, 0, 0, 0, 0);
        add(6, 1, 0, 0, 0, 0); add(1, 1, 0, 1, 0, 1); add(3, 1, 0, 1, 0, 0); add(10, 0, 0, 1, 0, 0);
        add(6, 1, 0, 1, 0, 0); add(1, 1, 0, 0, 0, 1); add(3, 1, 0, 0, 0, 0); add(10, 0, 0, 0, 0, 0);
        add(6, 0, 1, 0, 0, 0); add(1, 0, 1, 1, 1, 0); add(3, 0, 1, 1, 0, 0); add(10, 0, 0, 1, 0, 0);
        add(6, 1, 1, 1, 0, 0); add(1, 1, 1, 1, 1, 1); add(3, 1, 1, 1, 0, 0); add(10, 0, 0, 1, 0, 0);
        for (int i = 0; i < nvec; i++) begin
            btn_ss  = vecs[i].ss;
            btn_clr = vecs[i].cl;
            step();
            check($sformatf("row%0d {stop,clr,pulse}", i),
                  int'({stop, clr, ss_pulse}),
                  int'({vecs[i].exp_stop, vecs[i].exp_clr, vecs[i].exp_pulse}));
        end

        // 3a: bouncy press -> one pulse, 7 edges after the final rise
        btn_ss = 1'b1; step();
        btn_ss = 1'b0; step();
        btn_ss = 1'b1; step();
        btn_ss = 1'b0; step();
        btn_ss = 1'b1; mark();
        steps(15);
        check("bounce_pulse_count", np_ss, 1);
        check("bounce_pulse_edge", last_ss_edge, 7);
        check("bounce_stop", int'(stop), 0);
        btn_ss = 1'b0;
        steps(12);

        // 3b: 3-cycle glitch -> no pulse, still running
        mark();
        btn_ss = 1'b1;
        steps(3);
        btn_ss = 1'b0;
        steps(12);
        check("glitch_pulse_count", np_ss, 0);
        check("glitch_stop", int'(stop), 0);

        // Clear press to return to STOPPED before the long hold
        mark();
        btn_clr = 1'b1;
        steps(10);
        btn_clr = 1'b0;
        steps(10);
        check("clr_press_count", np_clr, 1);
        check("clr_press_stop", int'(stop), 1);

        // 5: hold start/stop for 40 cycles
        btn_ss = 1'b1;
        mark();
        stop_e7 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (ed == 7) stop_e7 = stop;
        end
        check("long_pulse_count", np_ss, 1);
        check("long_pulse_edge", last_ss_edge, 7);
        check("long_stop_at_e7", int'(stop_e7), 0);
`ifdef LONG_PRESS_EN
        check("long_clr_count", np_clr, 1);
        check("long_clr_edge", last_clr_edge, 26);
        check("long_stop_end", int'(stop), 1);
`else
        check("long_clr_count", np_clr, 0);
        check("long_stop_end", int'(stop), 0);
`endif
        btn_ss = 1'b0;
        steps(12);

        // 6: reset while the press is held; the button is released only after reset
        btn_clr = 1'b1; steps(10); btn_clr = 1'b0; steps(10);
        btn_ss = 1'b1;
        mark();
        steps(12);
        check("pre_reset_pulse", np_ss, 1);
        check("pre_reset_stop", int'(stop), 0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_reset_stop", int'(stop), 1);
        check("mid_reset_pulse", int'(ss_pulse), 0);
        steps(2);
        reset = 1'b0;
        mark();
        steps(15);
        btn_ss = 1'b0;
        steps(12);
        check("held_thru_reset_pulse", np_ss, 0);
        check("held_thru_reset_clr", np_clr, 0);
        check("held_thru_reset_stop", int'(stop), 1);
        btn_ss = 1'b1;
        mark();
        steps(10);
        check("post_reset_pulse_count", np_ss, 1);
        check("post_reset_pulse_edge", last_ss_edge, 7);
        check("post_reset_stop", int'(stop), 0);
        btn_ss = 1'b0;
        steps(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
